// File: rtl/fifo_pkg.sv
// Shared constants and arbiter state type for the FIFO command stage.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int RD_TIMEOUT = 15;

  // Bit positions of the strobes inside the {WE,RE,DI} instruction word
  localparam int INST_WE = DATA_WIDTH + 1;
  localparam int INST_RE = DATA_WIDTH;

  typedef enum logic {
    PRIO_WR = 1'b0,
    PRIO_RD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/fifo_occ_tracker.sv
// Occupancy, outstanding-read tracking and read-return watchdog for the FIFO.
// The watchdog is a down-counter reloaded whenever no read is waiting or a
// return arrives; its terminal count raises the sticky protocol error.
module fifo_occ_tracker
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_grant,
  input  logic                rd_grant,
  input  logic                read_valid,
  output logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                empty,
  output logic                protocol_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int TW    = $clog2(RD_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [TW-1:0]       TMR_LOAD = TW'(RD_TIMEOUT);
  localparam logic [TW-1:0]       TMR_ONE  = TW'(1);

  logic [ADDR_WIDTH:0] outstanding;
  logic [TW-1:0]       tmr_cnt;
  logic                rsp_match;
  logic                rsp_orphan;
  logic                tmr_active;
  logic                tmr_tc;

  assign rsp_match  = read_valid && (outstanding != '0);
  assign rsp_orphan = read_valid && (outstanding == '0);
  assign tmr_active = (outstanding != '0) && !read_valid;
  assign tmr_tc     = tmr_active && (tmr_cnt == TMR_ONE);

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // Committed occupancy; the arbiter never grants both sides in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (wr_grant) count <= count + CNT_ONE;
    else if (rd_grant) count <= count - CNT_ONE;
  end

  // Reads issued to the FIFO whose data has not come back yet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({rd_grant, rsp_match})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Return watchdog: reload while idle or on a return, otherwise count down to terminal
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  tmr_cnt <= '0;
    else if (!tmr_active)     tmr_cnt <= TMR_LOAD;
    else if (tmr_cnt != '0)   tmr_cnt <= tmr_cnt - TMR_ONE;
  end

  // Sticky error: orphan return or watchdog terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          protocol_err <= 1'b0;
    else if (rsp_orphan || tmr_tc)    protocol_err <= 1'b1;
  end

endmodule

// File: rtl/fifo_cmd_arbiter.sv
// Command stage in front of the single-port-RAM FIFO: arbitrates write and
// read requests into one {WE,RE,DI} word per cycle and registers read returns.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   PRIO_WR | write wins if both sides have a legal request
//   PRIO_RD | read wins if both sides have a legal request
//
// Priority only flips after a contended cycle; single-sided grants hold it.
module fifo_cmd_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  output logic [DATA_WIDTH+1:0] inst,
  input  logic                  read_valid,
  input  logic [DATA_WIDTH-1:0] DO,
  output logic                  rd_data_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  protocol_err
);

  localparam int WE_BIT = DATA_WIDTH + 1;
  localparam int RE_BIT = DATA_WIDTH;

  arb_state_t            state, state_nxt;
  logic                  wr_req, rd_req;
  logic                  wr_grant, rd_grant;
  logic [DATA_WIDTH+1:0] inst_nxt;

  assign wr_req       = wr_valid && !full;
  assign rd_req       = rd_req_valid && !empty;
  assign wr_ready     = wr_grant;
  assign rd_req_ready = rd_grant;

  // Arbiter state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PRIO_WR;
    else     state <= state_nxt;
  end

  // Grant selection, priority toggle on contention, and next instruction word
  always_comb begin
    state_nxt = state;
    wr_grant  = 1'b0;
    rd_grant  = 1'b0;
    inst_nxt  = '0;
    if (wr_req && rd_req) begin
      if (state == PRIO_WR) begin
        wr_grant  = 1'b1;
        state_nxt = PRIO_RD;
      end else begin
        rd_grant  = 1'b1;
        state_nxt = PRIO_WR;
      end
    end else begin
      wr_grant = wr_req;
      rd_grant = rd_req;
    end
    if (wr_grant) begin
      inst_nxt[WE_BIT]           = 1'b1;
      inst_nxt[DATA_WIDTH-1:0]   = wr_data;
    end else if (rd_grant) begin
      inst_nxt[RE_BIT]           = 1'b1;
    end
  end

  // Registered instruction to the FIFO block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inst <= '0;
    else     inst <= inst_nxt;
  end

  // Read return forwarded to the consumer one cycle later, no backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_data_valid <= read_valid;
      rd_data       <= DO;
    end
  end

  fifo_occ_tracker #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) u_occ (
    .clk          (clk),
    .rst          (rst),
    .wr_grant     (wr_grant),
    .rd_grant     (rd_grant),
    .read_valid   (read_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .protocol_err (protocol_err)
  );

endmodule

// File: tb/tb_fifo_cmd_arbiter.sv
// Directed bench for the FIFO command arbiter.
module tb_fifo_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_data = 8'h00;
  logic       rd_req_valid = 1'b0;
  logic       rd_req_ready;
  logic [9:0] inst;
  logic       read_valid = 1'b0;
  logic [7:0] DO = 8'h00;
  logic       rd_data_valid;
  logic [7:0] rd_data;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       protocol_err;

  int checks = 0;
  int failures = 0;

  fifo_cmd_arbiter #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (3),
    .RD_TIMEOUT (15)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .inst          (inst),
    .read_valid    (read_valid),
    .DO            (DO),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] exp_inst;

    // T1 reset held 3 cycles
    repeat (3) tick();
    check("t1_inst", 32'(inst), 32'h000);
    check("t1_count", 32'(count), 0);
    check("t1_empty", 32'(empty), 1);
    check("t1_full", 32'(full), 0);
    check("t1_err", 32'(protocol_err), 0);
    rst = 1'b0;
    tick();

    // T2 fill with back-to-back writes
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h11 + i);
      #1;
      check("t2_wr_ready", 32'(wr_ready), 1);
      tick();
      exp_inst = 10'(10'h211 + i);
      check("t2_inst", 32'(inst), 32'(exp_inst));
      check("t2_count", 32'(count), 32'(i + 1));
    end
    check("t2_full", 32'(full), 1);
    check("t2_empty", 32'(empty), 0);
    wr_data = 8'h19;
    #1;
    check("t2_wr_ready_full", 32'(wr_ready), 0);
    tick();
    check("t2_inst_full", 32'(inst), 32'h000);
    check("t2_count_full", 32'(count), 8);
    wr_valid = 1'b0;

    // Drain to 4 entries
    for (int i = 0; i < 4; i++) begin
      rd_req_valid = 1'b1;
      #1;
      check("drain_rd_ready", 32'(rd_req_ready), 1);
      tick();
      check("drain_inst", 32'(inst), 32'h100);
    end
    rd_req_valid = 1'b0;
    check("drain_count", 32'(count), 4);

    // T3 contention: alternating grants starting with write
    wr_valid     = 1'b1;
    rd_req_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'(8'h30 + i);
      #1;
      check("t3_wr_ready", 32'(wr_ready), (i % 2 == 0) ? 1 : 0);
      check("t3_rd_ready", 32'(rd_req_ready), (i % 2 == 1) ? 1 : 0);
      tick();
      exp_inst = (i % 2 == 0) ? 10'(10'h230 + i) : 10'h100;
      check("t3_inst", 32'(inst), 32'(exp_inst));
      check("t3_not_both", 32'(inst[9:8] == 2'b11), 0);
    end
    wr_valid     = 1'b0;
    rd_req_valid = 1'b0;
    check("t3_count", 32'(count), 4);

    // T4 read request while empty
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_count_rst", 32'(count), 0);
    check("t4_empty", 32'(empty), 1);
    rd_req_valid = 1'b1;
    #1;
    check("t4_rd_ready", 32'(rd_req_ready), 0);
    tick();
    check("t4_inst", 32'(inst), 32'h000);
    check("t4_count", 32'(count), 0);
    rd_req_valid = 1'b0;

    // T5 return path and orphan return
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    tick();
    check("t5_wr_inst", 32'(inst), 32'h2A5);
    check("t5_count1", 32'(count), 1);
    wr_valid     = 1'b0;
    rd_req_valid = 1'b1;
    tick();
    check("t5_rd_inst", 32'(inst), 32'h100);
    check("t5_count0", 32'(count), 0);
    rd_req_valid = 1'b0;
    read_valid   = 1'b1;
    DO           = 8'hA5;
    tick();
    check("t5_rdv", 32'(rd_data_valid), 1);
    check("t5_rd_data", 32'(rd_data), 32'hA5);
    check("t5_err_clean", 32'(protocol_err), 0);
    read_valid = 1'b0;
    DO         = 8'h00;
    tick();
    check("t5_rdv_low", 32'(rd_data_valid), 0);
    check("t5_rd_data_low", 32'(rd_data), 0);
    check("t5_err_still_clean", 32'(protocol_err), 0);
    read_valid = 1'b1;
    DO         = 8'h5A;
    tick();
    read_valid = 1'b0;
    check("t5_orphan_data", 32'(rd_data), 32'h5A);
    check("t5_orphan_err", 32'(protocol_err), 1);

    // T6 read timeout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_err_rst", 32'(protocol_err), 0);
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    tick();
    wr_valid     = 1'b0;
    rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    check("t6_rd_inst", 32'(inst), 32'h100);
    repeat (12) tick();
    check("t6_err_early", 32'(protocol_err), 0);
    repeat (4) tick();
    check("t6_err_timeout", 32'(protocol_err), 1);

    // T6 reset in the middle of a write burst
    wr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr_data = 8'(8'hC0 + i);
      tick();
      exp_inst = 10'(10'h2C0 + i);
      check("t6_burst_inst", 32'(inst), 32'(exp_inst));
    end
    check("t6_burst_count", 32'(count), 2);
    wr_data = 8'hC2;
    rst     = 1'b1;
    #1;
    check("t6_rst_inst", 32'(inst), 32'h000);
    check("t6_rst_count", 32'(count), 0);
    check("t6_rst_err", 32'(protocol_err), 0);
    wr_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("t6_post_inst", 32'(inst), 32'h000);
    check("t6_post_empty", 32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
